// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// prefix scan codes and the frame validity rule.
package ps2_pkg;

  typedef logic [7:0] scan_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam scan_code_t PS2_EXT_CODE   = 8'hE0;
  localparam scan_code_t PS2_BREAK_CODE = 8'hF0;

  // A frame is good when data plus parity hold an odd number of ones and the
  // stop bit is high.
  function automatic logic frame_ok(input scan_code_t data, input logic parity,
                                    input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Key event bus produced by ps2_keyboard_rx: decoded key events plus an
// error strobe for malformed or abandoned frames.
interface ps2_keyboard_rx_if;
  import ps2_pkg::*;

  logic       key_valid;
  scan_code_t key_code;
  logic       key_extended;
  logic       key_release;
  logic       rx_error;

  modport master (
    output key_valid,
    output key_code,
    output key_extended,
    output key_release,
    output rx_error
  );

  modport slave (
    input key_valid,
    input key_code,
    input key_extended,
    input key_release,
    input rx_error
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter for one PS/2 line;
// the filtered output only follows the line after FILTER_LEN equal samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] run_cnt;

  // Both stages reset high so an idle line is seen as idle right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, independent of order.
      sync_q <= {sync_q[0], line_raw};
    end
  end

  // run_cnt counts consecutive synchronized samples that disagree with the
  // current output; the output flips on the FILTER_LEN-th one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_filt <= 1'b1;
      run_cnt   <= '0;
    end else if (sync_q[1] == line_filt) begin
      run_cnt <= '0;
    end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
      line_filt <= sync_q[1];
      run_cnt   <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filters both lines, frames 11-bit words on falling
// filtered clock edges, enforces an inter-edge timeout and decodes E0/F0 prefixes.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master key_if
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic clk_filt;
  logic data_filt;
  logic clk_filt_d;
  logic sample;

  frame_state_t state, state_next;
  logic [2:0]   bit_cnt, bit_cnt_next;
  scan_code_t   shift_q, shift_next;
  logic         parity_q, parity_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic         timeout;
  logic         byte_ok;
  logic         frame_err;

  logic         ext_flag;
  logic         rel_flag;
  logic         key_valid_q;
  scan_code_t   key_code_q;
  logic         key_extended_q;
  logic         key_release_q;
  logic         rx_error_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_raw  (ps2_clk),
    .line_filt (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_raw  (ps2_data),
    .line_filt (data_filt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_filt_d <= 1'b1;
    else          clk_filt_d <= clk_filt;
  end

  assign sample  = clk_filt_d & ~clk_filt;
  assign timeout = (state != ST_IDLE) && !sample &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      shift_q  <= shift_next;
      parity_q <= parity_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_q;
    parity_next  = parity_q;
    byte_ok      = 1'b0;
    frame_err    = 1'b0;

    if (timeout) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      shift_next   = '0;
      frame_err    = 1'b1;
    end else if (sample) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_filt) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
        ST_DATA: begin
          shift_next   = {data_filt, shift_q[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
          parity_next = data_filt;
          state_next  = ST_STOP;
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          if (frame_ok(shift_q, parity_q, data_filt)) byte_ok   = 1'b1;
          else                                        frame_err = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Idle-time watchdog; only runs while a frame is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE || sample || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Prefix decoder and output registers. Errors and accepted bytes come from
  // exclusive FSM paths, so key_valid and rx_error can never coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_flag       <= 1'b0;
      rel_flag       <= 1'b0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_extended_q <= 1'b0;
      key_release_q  <= 1'b0;
      rx_error_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      rx_error_q  <= 1'b0;
      if (frame_err) begin
        rx_error_q <= 1'b1;
        ext_flag   <= 1'b0;
        rel_flag   <= 1'b0;
      end else if (byte_ok) begin
        if (shift_q == PS2_EXT_CODE) begin
          ext_flag <= 1'b1;
        end else if (shift_q == PS2_BREAK_CODE) begin
          rel_flag <= 1'b1;
        end else begin
          key_valid_q    <= 1'b1;
          key_code_q     <= shift_q;
          key_extended_q <= ext_flag;
          key_release_q  <= rel_flag;
          ext_flag       <= 1'b0;
          rel_flag       <= 1'b0;
        end
      end
    end
  end

  assign key_if.key_valid    = key_valid_q;
  assign key_if.key_code     = key_code_q;
  assign key_if.key_extended = key_extended_q;
  assign key_if.key_release  = key_release_q;
  assign key_if.rx_error     = rx_error_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus random
// frames, compared against a byte-level model of the PS/2 prefix protocol.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 25;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_t;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_rx_if kif ();

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (kif.master)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall = 0;
  int   both_cnt = 0;
  int   got_err = 0;
  int   exp_err = 0;
  int   err_cyc[$];
  key_t got_q[$];
  key_t exp_q[$];
  logic m_ext = 1'b0;
  logic m_rel = 1'b0;
  key_t last_key = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.key_valid) got_q.push_back(key_t'{kif.key_code, kif.key_extended, kif.key_release});
    if (kif.rx_error) begin
      got_err = got_err + 1;
      err_cyc.push_back(cyc);
    end
    if (kif.key_valid && kif.rx_error) both_cnt = both_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-level protocol model: any bad frame is an error that drops prefixes,
  // E0/F0 set flags, anything else is a key event carrying the flags.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
    if (!((^{b, par}) && stop)) begin
      exp_err++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      last_key = key_t'{b, m_ext, m_rel};
      exp_q.push_back(last_key);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic model_error();
    exp_err++;
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
    model_frame(b, par, !bad_stop);
  endtask

  task automatic compare(input string tag);
    tick(HALF + FL + 10);
    check({tag, " key count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, " key event"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    check({tag, " error count"}, 32'(got_err), 32'(exp_err));
    check({tag, " held outputs"},
          32'({kif.key_code, kif.key_extended, kif.key_release}), 32'(last_key));
    got_q.delete();
    exp_q.delete();
    err_cyc.delete();
    got_err = 0;
    exp_err = 0;
  endtask

  initial begin
    int d;
    int r;
    logic [7:0] b;

    tick(5);
    check("reset key_valid", 32'(kif.key_valid), 32'd0);
    check("reset key_code", 32'(kif.key_code), 32'd0);
    check("reset key_extended", 32'(kif.key_extended), 32'd0);
    check("reset key_release", 32'(kif.key_release), 32'd0);
    check("reset rx_error", 32'(kif.rx_error), 32'd0);
    reset_n = 1'b1;
    tick(20);

    send_frame(8'h1C, 0, 0);
    compare("make 1C");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    compare("break 1C");

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    compare("ext break 75");
    send_frame(8'h29, 0, 0);
    compare("plain 29");

    send_frame(8'h1C, 1, 0);
    compare("bad parity 1C");
    send_frame(8'h1C, 0, 0);
    compare("recover 1C");

    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 0, 1);
    send_frame(8'h5A, 0, 0);
    compare("bad stop clears ext");

    send_frame(8'hE0, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    compare("repeated prefixes");

    send_frame(8'hF0, 0, 0);
    send_bit(1'b1);
    model_error();
    send_frame(8'h1C, 0, 0);
    compare("start error clears rel");

    // Abandoned frame: start plus four data bits, then silence.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    tick(2 * TO);
    model_error();
    d = (err_cyc.size() > 0) ? err_cyc[0] - last_fall : -1;
    check("timeout delay in window", 32'(d >= TO && d <= TO + FL + 12), 32'd1);
    compare("timeout");
    send_frame(8'h29, 0, 0);
    compare("after timeout 29");

    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(50);
    compare("clk glitch ignored");

    send_frame(8'hE0, 0, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    reset_n  = 1'b0;
    tick(1);
    check("mid-frame reset key_code", 32'(kif.key_code), 32'd0);
    check("mid-frame reset rx_error", 32'(kif.rx_error), 32'd0);
    tick(3);
    reset_n  = 1'b1;
    last_key = '0;
    m_ext    = 1'b0;
    m_rel    = 1'b0;
    tick(50);
    compare("after reset quiet");
    send_frame(8'h1C, 0, 0);
    compare("after reset 1C");

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r < 2) send_frame(8'hE0, 0, 0);
      if (r >= 1 && r < 4) send_frame(8'hF0, 0, 0);
      send_frame(b, r == 9, r == 8);
      compare("random");
    end

    check("no key_valid with rx_error", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, is the number of consecutive equal samples needed before a filtered PS/2 line changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000 (1 ms at 100 MHz), is the number of idle clk cycles inside a frame before the frame is aborted.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous, idle high.
REQ-006 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous, idle high.
REQ-007 key_valid  output  1  one-cycle pulse: key_code/key_extended/key_release valid.
REQ-008 key_code  output  8  scan code (set 2) of the completed key event.
REQ-009 key_extended  output  1  event was prefixed by 0xE0.
REQ-010 key_release  output  1  event was prefixed by 0xF0 (break code).
REQ-011 rx_error  output  1  one-cycle pulse on start, parity, stop or timeout error.

Function
REQ-012 Each PS/2 line SHALL pass through a 2-FF synchronizer, then a filter whose output changes only after FILTER_LEN consecutive equal synchronized samples.
REQ-013 A sample event SHALL occur on the cycle in which filtered ps2_clk goes 1->0; filtered ps2_data is sampled on that cycle.
REQ-014 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sample with data=0 -> DATA, bit counter=0; sample with data=1 -> stay IDLE, pulse rx_error.
REQ-016 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: record parity bit; -> STOP.
REQ-018 STOP: frame good iff the 8 data bits plus the parity bit contain an odd number of ones and the stop bit = 1; good -> byte accepted, bad -> rx_error pulse; either case -> IDLE.
REQ-019 Timeout: in any non-IDLE state, TIMEOUT_CYCLES cycles without a sample event -> IDLE, pulse rx_error, discard partial byte; the counter clears on every sample event and in IDLE.
REQ-020 Decoder, on an accepted byte: 0xE0 sets the ext flag, no output; 0xF0 sets the rel flag, no output; any other byte pulses key_valid.
REQ-021 key_valid SHALL be asserted on the cycle after the stop-bit sample event, together with key_code = byte, key_extended = ext, key_release = rel; both flags clear in the same cycle.
REQ-022 key_code/key_extended/key_release SHALL hold their values until the next key_valid.
REQ-023 Any rx_error SHALL clear the ext and rel flags.
REQ-024 Repeated prefixes (E0 E0, F0 F0) SHALL leave the flag set with no error.
REQ-025 key_valid and rx_error SHALL never be asserted in the same cycle.

Reset
REQ-026 While reset_n=0: FSM IDLE, counters 0, shift register 0, flags 0, all outputs 0; synchronizer and filter states =1 (line idle).
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, reception restarts at the next start bit with no spurious key_valid or rx_error.

Structure
REQ-028 Shared package ps2_pkg SHALL hold the FSM state encoding and the constants PS2_EXT_CODE=0xE0 and PS2_BREAK_CODE=0xF0.
REQ-029 Sub-module ps2_line_filter (synchronizer + filter) SHALL be instantiated once per PS/2 line; framing, timeout and decode remain in ps2_keyboard_rx.

Verification
REQ-030 Frame 0x1C, parity 0, 10 kHz bit rate -> exactly one key_valid, key_code=0x1C, key_extended=0, key_release=0.
REQ-031 Frames F0,1C -> exactly one key_valid with key_code=0x1C, key_release=1, key_extended=0.
REQ-032 Frames E0,F0,75 -> exactly one key_valid with key_code=0x75, key_extended=1, key_release=1; a following 0x29 frame -> 0x29 with both flags 0.
REQ-033 Frame 0x1C with parity bit=1 -> one rx_error pulse, no key_valid; a following good 0x1C frame decodes normally.
REQ-034 Stop after 4 data bits, lines idle for 2 ms -> one rx_error pulse about 1 ms after the last edge; a following 0x29 frame -> key_code=0x29.
REQ-035 3-cycle low glitch on ps2_clk while idle, then reset_n low for 4 cycles mid-frame -> no sample event, no outputs; the next full 0x1C frame -> key_code=0x1C.
